// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and the IF/ID entry layout consumed by decode.
package fetch_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic [31:0] instr;
    logic        pred;
    logic        valid;
  } if_id_t;

  // A bubble keeps the PC bookkeeping but carries a NOP that decode ignores.
  function automatic if_id_t bubble_entry(input logic [31:0] pc, input logic [31:0] nop);
    if_id_t e;
    e.pc      = pc;
    e.pc_four = pc + 32'd4;
    e.instr   = nop;
    e.pred    = 1'b0;
    e.valid   = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise the entry holds.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] P_NOP = NOP_INSTR
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t entry_i,
  output if_id_t entry_o
);

  if_id_t entry_q;
  if_id_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (bubble_i) begin
      entry_d = bubble_entry(entry_i.pc, P_NOP);
    end else if (load_i) begin
      entry_d = entry_i;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      entry_q <= bubble_entry(32'h0000_0000, P_NOP);
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, imem addressing and the
// IF/ID register feeding decode, plus fetch/flush event counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = RESET_PC,
  parameter logic [31:0] P_NOP      = NOP_INSTR
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall_FD,
  input  logic        i_flush_D,
  input  logic        i_mispredict_E,
  input  logic        i_prediction_F,
  input  logic [31:0] i_PCTarget_F,
  output logic [31:0] o_PC_F,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_PC_D,
  output logic [31:0] o_instr_D,
  output logic [31:0] o_pc_four_D,
  output logic [1:0]  o_index_D,
  output logic        o_pred_D,
  output logic        o_valid_D,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_flush_cnt
);

  logic [31:0] pc_q, pc_d;
  logic        boot_q;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        adv;
  logic        kill;
  logic        load;
  logic        bubble;
  if_id_t      fetch_entry;
  if_id_t      dec_entry;

  assign pc_plus4 = pc_q + 32'd4;

  // Both a correction and a predicted-taken redirect arrive on i_PCTarget_F.
  assign next_pc = (i_mispredict_E || i_prediction_F) ? i_PCTarget_F : pc_plus4;

  // During boot the imem has no valid word yet, so the PC must not move.
  assign adv  = !boot_q && (!i_stall_FD || i_mispredict_E);
  assign kill = i_mispredict_E || i_flush_D;

  assign bubble = kill || (!i_stall_FD && boot_q);
  assign load   = !kill && !i_stall_FD && !boot_q;

  always_comb begin
    pc_d        = adv ? next_pc : pc_q;
    fetch_cnt_d = load ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    flush_cnt_d = kill ? flush_cnt_q + 32'd1 : flush_cnt_q;
  end

  // ---- IF stage: PC, boot flag and counters ----
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pc_q        <= P_RESET_PC;
      boot_q      <= 1'b1;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      boot_q      <= 1'b0;
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Whenever boot is clear the imem output is the word at pc_q.
  assign fetch_entry.pc      = pc_q;
  assign fetch_entry.pc_four = pc_plus4;
  assign fetch_entry.instr   = i_imem_rdata;
  assign fetch_entry.pred    = i_prediction_F;
  assign fetch_entry.valid   = 1'b1;

  // ---- IF/ID boundary ----
  if_id_reg #(
    .P_NOP(P_NOP)
  ) u_if_id (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load_i  (load),
    .bubble_i(bubble),
    .entry_i (fetch_entry),
    .entry_o (dec_entry)
  );

  assign o_PC_F      = pc_q;
  assign o_imem_addr = adv ? next_pc : pc_q;
  assign o_PC_D      = dec_entry.pc;
  assign o_instr_D   = dec_entry.instr;
  assign o_pc_four_D = dec_entry.pc_four;
  assign o_index_D   = dec_entry.pc[3:2];
  assign o_pred_D    = dec_entry.pred;
  assign o_valid_D   = dec_entry.valid;
  assign o_fetch_cnt = fetch_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference PC model plus a scoreboard of
// expected decode entries, against a 1-cycle-latency instruction memory.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, misp, pred;
  logic [31:0] tgt;
  logic [31:0] pc_f, imem_addr, imem_rdata;
  logic [31:0] pc_d, instr_d, pc_four_d, fetch_cnt, flush_cnt;
  logic [1:0]  index_d;
  logic        pred_d, valid_d;

  int n_cmp = 0;
  int n_bad = 0;

  if_id_t      sb_q[$];
  if_id_t      m_d;
  logic        m_d_pc_ok;
  logic [31:0] m_pc;
  logic        m_boot;
  logic [31:0] m_fetch, m_flush;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  fetch_stage dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall_FD    (stall),
    .i_flush_D     (flush),
    .i_mispredict_E(misp),
    .i_prediction_F(pred),
    .i_PCTarget_F  (tgt),
    .o_PC_F        (pc_f),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .o_PC_D        (pc_d),
    .o_instr_D     (instr_d),
    .o_pc_four_D   (pc_four_d),
    .o_index_D     (index_d),
    .o_pred_D      (pred_d),
    .o_valid_D     (valid_d),
    .o_fetch_cnt   (fetch_cnt),
    .o_flush_cnt   (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_boot    = 1'b1;
    m_d       = bubble_entry(32'h0, NOP_INSTR);
    m_d_pc_ok = 1'b1;
    m_fetch   = 0;
    m_flush   = 0;
    sb_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc_f"},    pc_f, RESET_PC);
    chk({tag, "_imem"},    imem_addr, RESET_PC);
    chk({tag, "_pc_d"},    pc_d, 32'h0);
    chk({tag, "_instr"},   instr_d, NOP_INSTR);
    chk({tag, "_pc4"},     pc_four_d, 32'h4);
    chk({tag, "_pred"},    {31'b0, pred_d}, 32'h0);
    chk({tag, "_valid"},   {31'b0, valid_d}, 32'h0);
    chk({tag, "_fcnt"},    fetch_cnt, 32'h0);
    chk({tag, "_flcnt"},   flush_cnt, 32'h0);
  endtask

  // One clock of stimulus; inputs are applied 1 ns after the previous edge.
  task automatic cyc(input logic st, input logic fl, input logic mp, input logic pr,
                     input logic [31:0] tg);
    logic        ld, kl, adv;
    logic [31:0] nxt;
    if_id_t      e;
    stall = st; flush = fl; misp = mp; pred = pr; tgt = tg;
    #1;
    kl  = mp || fl;
    ld  = !m_boot && !kl && !st;
    adv = !m_boot && (!st || mp);
    nxt = (mp || pr) ? tg : m_pc + 32'd4;
    chk("imem_addr", imem_addr, adv ? nxt : m_pc);
    if (ld) begin
      e.pc = m_pc; e.pc_four = m_pc + 32'd4; e.instr = mem_word(m_pc);
      e.pred = pr; e.valid = 1'b1;
      sb_q.push_back(e);
      m_fetch++;
    end
    if (kl) m_flush++;
    @(posedge clk);
    #1;
    if (kl || (!st && m_boot)) begin
      m_d       = bubble_entry(m_pc, NOP_INSTR);
      m_d_pc_ok = kl;
    end else if (ld) begin
      m_d       = sb_q.pop_front();
      m_d_pc_ok = 1'b1;
    end
    if (adv) m_pc = nxt;
    m_boot = 1'b0;
    chk("pc_f",    pc_f, m_pc);
    chk("valid_d", {31'b0, valid_d}, {31'b0, m_d.valid});
    chk("instr_d", instr_d, m_d.instr);
    chk("pred_d",  {31'b0, pred_d}, {31'b0, m_d.pred});
    if (m_d_pc_ok) begin
      chk("pc_d",      pc_d, m_d.pc);
      chk("pc_four_d", pc_four_d, m_d.pc_four);
      chk("index_d",   {30'b0, index_d}, {30'b0, m_d.pc[3:2]});
    end
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("flush_cnt", flush_cnt, m_flush);
  endtask

  initial begin
    rst = 1'b0; stall = 0; flush = 0; misp = 0; pred = 0; tgt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b1;

    cyc(0, 0, 0, 0, 0);                 // boot bubble
    cyc(0, 0, 0, 0, 0);                 // D = 0x0
    cyc(0, 0, 0, 0, 0);                 // D = 0x4
    cyc(0, 0, 0, 1, 32'h40);            // D = 0x8 pred, pc_f -> 0x40
    chk("fetch_cnt_3", fetch_cnt, 32'd3);
    chk("pred_8", {31'b0, pred_d}, 32'd1);
    cyc(0, 0, 0, 0, 0);                 // D = 0x40, no bubble
    chk("pc_d_40", pc_d, 32'h40);

    cyc(0, 0, 0, 1, 32'h10);            // D = 0x44, pc_f -> 0x10
    repeat (3) cyc(1, 0, 0, 1, 32'h200); // stalled: prediction ignored
    chk("stall_pc_f", pc_f, 32'h10);
    chk("stall_pc_d", pc_d, 32'h44);
    cyc(0, 0, 0, 0, 0);                 // D = 0x10
    chk("rel_pc_d", pc_d, 32'h10);
    cyc(0, 0, 0, 0, 0);                 // D = 0x14

    cyc(1, 0, 1, 0, 32'h80);            // mispredict overrides stall
    chk("misp_pc_f", pc_f, 32'h80);
    chk("misp_instr", instr_d, 32'h13);
    chk("misp_flcnt", flush_cnt, 32'd1);
    cyc(0, 0, 0, 0, 0);                 // D = 0x80
    chk("misp_next", pc_d, 32'h80);
    cyc(0, 1, 0, 0, 0);                 // decode flush
    cyc(0, 0, 0, 0, 0);

    cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);                 // D = 0xFFFFFFFC, pc_f wraps
    chk("wrap_pc_f", pc_f, 32'h0);
    chk("wrap_pc4", pc_four_d, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    stall = 1'b1;                       // async reset while stalled
    #2;
    rst = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0, 0);                 // boot bubble again
    cyc(0, 0, 0, 0, 0);                 // D = reset PC
    chk("resume_pc_d", pc_d, RESET_PC);
    cyc(0, 0, 0, 0, 0);
    chk("resume_fcnt", fetch_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the 5-stage pipelined core.
- Owns PC_F and drives it to the branch predictor every cycle.
- Takes the predictor's taken/target and the execute-stage mispredict to select the next PC.
- Drives the synchronous (1-cycle read latency) instruction memory and presents PC, instruction, PC+4 and the prediction bit to decode.

Parameters:
- P_RESET_PC, 32'h0000_0000, PC fetched first after reset.
- P_NOP, 32'h0000_0013, instruction injected into decode on a bubble or flush (addi x0,x0,0).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- i_stall_FD  in  1  hazard unit: hold PC_F and the IF/ID register
- i_flush_D  in  1  hazard unit: replace the decode entry with a bubble
- i_mispredict_E  in  1  execute-stage misprediction or jump; i_PCTarget_F then carries the corrected PC
- i_prediction_F  in  1  predictor: redirect fetch to i_PCTarget_F
- i_PCTarget_F  in  32  predictor target (predicted or corrected)
- o_PC_F  out  32  current fetch PC, to the predictor
- o_imem_addr  out  32  instruction memory read address, sampled at the clock edge
- i_imem_rdata  in  32  instruction memory data for the address sampled at the previous edge
- o_PC_D  out  32  decode PC
- o_instr_D  out  32  decode instruction
- o_pc_four_D  out  32  o_PC_D + 4
- o_index_D  out  2  o_PC_D[3:2], to the predictor
- o_pred_D  out  1  prediction taken at fetch for this instruction
- o_valid_D  out  1  decode entry is a real instruction, not a bubble
- o_fetch_cnt  out  32  instructions written into IF/ID with valid=1
- o_flush_cnt  out  32  cycles in which a flush or redirect killed the decode entry

Behaviour:
- Reset (i_rst=0, asynchronous):
  - pc_f=P_RESET_PC; boot=1.
  - o_PC_D=0, o_instr_D=P_NOP, o_pc_four_D=4, o_pred_D=0, o_valid_D=0.
  - Both counters 0.
  - o_imem_addr=P_RESET_PC.
- Boot cycle (first cycle after reset release, boot=1):
  - o_imem_addr=pc_f; pc_f holds.
  - Decode gets a bubble (valid=0, not counted).
  - boot clears at the edge.
- next_pc priority:
  - i_mispredict_E -> i_PCTarget_F
  - else i_prediction_F -> i_PCTarget_F
  - else pc_f+4, modulo 2^32 (wraps 0xFFFF_FFFC -> 0).
- Advance condition: adv = !boot && (!i_stall_FD || i_mispredict_E). A mispredict overrides stall.
- o_imem_addr = adv ? next_pc : pc_f.
  - Invariant: whenever boot=0, i_imem_rdata is the word at pc_f.
- On adv, pc_f <= next_pc.
- IF/ID update at each edge, highest priority first:
  - (a) i_mispredict_E or i_flush_D (regardless of stall): bubble written; o_PC_D etc. still take pc_f values; flush_cnt+1.
  - (b) else i_stall_FD: all D outputs hold.
  - (c) else boot: bubble.
  - (d) else o_PC_D<=pc_f, o_instr_D<=i_imem_rdata, o_pc_four_D<=pc_f+4, o_pred_D<=i_prediction_F, o_valid_D<=1; fetch_cnt+1.
- Bubble definition: instr=P_NOP, valid=0, pred=0.
- Counters wrap at 2^32.
- o_PC_F = pc_f (combinational from the register).
- o_index_D = o_PC_D[3:2] (combinational).
- Predicted-taken fetch needs no flush: the target is loaded into pc_f in the same cycle and fetched next.
- i_prediction_F is ignored while boot=1 and while stalled without a mispredict.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight imem data is discarded via the boot cycle.
- No combinational path from i_imem_rdata to any output.

Decomposition:
- Package fetch_pkg:
  - RESET_PC and NOP_INSTR constants.
  - Opcode constant for B-type (7'b1100011).
  - Packed typedef if_id_t {pc, pc_four, instr, pred, valid}, shared with the decode stage.
- One sub-module, if_id_reg: holds if_id_t, with load/hold/bubble control and asynchronous active-low reset to the bubble value.
- PC register, next-PC mux, boot flag and counters stay in fetch_stage.

Test Plan:
- Reset release, memory word[n]=0x1000_0000+n, no stalls:
  - Cycle 1 D is a bubble.
  - D then shows PC 0,4,8 with instr 0x1000_0000, 0x1000_0001, 0x1000_0002, valid=1.
  - fetch_cnt=3 after three valid loads.
- i_prediction_F=1 with target 0x40 while pc_f=0x8:
  - Next pc_f=0x40.
  - D gets PC 0x8 with pred=1.
  - Next D is PC 0x40, with no bubble in between.
- i_stall_FD held 3 cycles at pc_f=0x10:
  - pc_f, o_imem_addr=0x10 and all D outputs frozen.
  - After release, D=PC 0x10, then 0x14, with nothing lost or duplicated.
- i_mispredict_E=1 with i_PCTarget_F=0x80, and i_stall_FD=1 in the same cycle:
  - pc_f=0x80.
  - D becomes bubble (instr 0x13, valid 0); flush_cnt+1.
  - Next D is PC 0x80.
- pc_f=0xFFFF_FFFC, no prediction: next pc_f=0x0, and o_pc_four_D for that instruction=0x0.
- Assert i_rst for 1 cycle mid-stream, while stalled:
  - All outputs return to reset values immediately; counters cleared.
  - Boot bubble, then fetch resumes at P_RESET_PC.
